msj_pd_scheduler: RTL and testbench
===================================

Name: msj_pd_scheduler

Overview:
Time-multiplexes one shared PD controller datapath across NUM_MOTORS MSJ platform motors.
- A periodic tick starts a sweep over all motors. For each enabled motor the block selects it, pulses the controller update strobe, waits for the result, and latches the returned PWM reference into that motor's output register.
- Placement: between the per-motor config/sensor muxes (driven by motor_sel) and the PWM generators (driven by pwm_out).

Parameters:
NUM_MOTORS, 8, number of motors sharing the controller
TICK_DIV, 500000, clock cycles per sweep period (50 MHz / 100 Hz)
SETTLE_CYCLES, 2, cycles waited after the update pulse before capturing pwm_ref_in (min 1)
IDX_W, $clog2(NUM_MOTORS), width of motor_sel

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
enable_mask  in  NUM_MOTORS  per-motor enable, sampled at sweep start
estop  in  1  emergency stop, synchronous, level
overrun_clear  in  1  clears overrun flag
pwm_ref_in  in  32 signed  result from shared PD controller
motor_sel  out  IDX_W  index driving the controller input muxes
ctrl_update  out  1  update strobe to controller (rising-edge sensitive)
pwm_out  out  NUM_MOTORS*32  per-motor signed PWM reference, motor i at [32*i+31:32*i]
pwm_valid  out  NUM_MOTORS  one-cycle pulse when pwm_out[i] is written
sweep_done  out  1  one-cycle pulse at end of sweep
busy  out  1  high while sweep in progress
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; tick counter 0; latched mask 0.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 continuously, ignoring FSM state.
  - tick=1 in the cycle where count==TICK_DIV-1, so the first tick occurs TICK_DIV cycles after reset release.
- FSM states: IDLE, SELECT, PULSE, WAIT, CAPTURE, NEXT, DONE.
- IDLE:
  - On tick: latch enable_mask, idx<=0, go to SELECT.
  - busy=1 from the cycle after the tick until DONE inclusive.
- SELECT: motor_sel=idx.
  - If mask[idx]=1, go to PULSE.
  - Otherwise write pwm_out[idx]<=0 without pulsing pwm_valid, then go to NEXT.
- PULSE: ctrl_update=1 for exactly one cycle; motor_sel holds. Go to WAIT with wait counter 0.
- WAIT: ctrl_update=0. Stay SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: pwm_out[idx]<=pwm_ref_in; pwm_valid[idx]=1 for one cycle. Go to NEXT.
- NEXT:
  - If idx==NUM_MOTORS-1, go to DONE; otherwise idx<=idx+1 and go to SELECT.
  - idx never wraps mid-sweep.
- DONE: sweep_done=1 for one cycle; go to IDLE.
- Cycle costs:
  - Enabled motor: SETTLE_CYCLES+4 cycles (SELECT, PULSE, WAIT×S, CAPTURE, NEXT).
  - Disabled motor: 2 cycles (SELECT, NEXT).
- ctrl_update is always low for at least one cycle before each rise (the SELECT cycle), so a rising-edge-detecting controller sees every pulse.
- motor_sel is stable from SELECT through CAPTURE. It holds its last value in IDLE.
- Overrun:
  - A tick while FSM is not IDLE sets overrun=1; that tick is dropped and the running sweep continues.
  - overrun_clear clears the flag. If clear and a new overrun occur in the same cycle, set wins.
- Tick in DONE counts as overrun; the sweep starts on the next tick only.
- estop=1:
  - Every cycle: pwm_out all 0, pwm_valid 0, ctrl_update 0, FSM forced to IDLE, sweep_done not pulsed. Ticks are ignored and overrun is not set.
  - On estop deassert the FSM waits in IDLE for the next tick.
- Values pass through unchanged as 32-bit signed. No saturation; clamping is the controller's job.
- enable_mask changes mid-sweep have no effect until the next sweep.

Decomposition:
- Package msj_pd_sched_pkg:
  - state enum sched_state_t {IDLE, SELECT, PULSE, WAIT, CAPTURE, NEXT, DONE};
  - localparam PWM_W=32.
- Sub-module msj_tick_gen (param TICK_DIV; ports clock, reset, tick): isolates the free-running period counter.

Test Plan:
Bench uses NUM_MOTORS=4, TICK_DIV=64, SETTLE_CYCLES=2. Controller model: on each ctrl_update rising edge, pwm_ref_in<=(motor_sel+1)*100 one cycle later.
1. Basic sweep: mask=4'b1111 -> first tick at cycle 64; pwm_out = {400,300,200,100}; exactly 4 ctrl_update pulses, each 6 cycles apart; pwm_valid 0..3 pulse in order; sweep_done 25 cycles after the tick; overrun=0.
2. Masked motors: mask=4'b0101 -> pulses only for motor_sel 0 and 2; pwm_out[1]=pwm_out[3]=0; pwm_valid[1], pwm_valid[3] never assert; sweep length 17 cycles.
3. Overrun: TICK_DIV=16, mask=4'b1111 -> second tick arrives while busy, overrun=1 and sticky; sweep completes normally; overrun_clear pulse -> overrun=0 unless the same cycle overruns.
4. Estop mid-sweep: assert estop during motor 2 WAIT -> next cycle all pwm_out=0, busy=0, no sweep_done; release -> next tick restarts from motor 0.
5. Async reset mid-PULSE: reset asserted while ctrl_update=1 -> outputs 0 immediately (no clock edge needed); after release the first tick is 64 cycles later.
6. Mask change mid-sweep: flip mask 4'b1111->4'b0000 during motor 1 -> current sweep still updates all 4 motors; next sweep produces all zeros and no ctrl_update pulses.

Source files
------------

// File: rtl/msj_pd_sched_pkg.sv
// Shared types and widths for the MSJ PD controller scheduler.
package msj_pd_sched_pkg;

  localparam int unsigned PWM_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    WAIT,
    CAPTURE,
    NEXT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/msj_pd_scheduler_if.sv
// Bus between the scheduler, the controller input muxes and the PWM generators.
interface msj_pd_scheduler_if #(
  parameter int unsigned NUM_MOTORS = 8,
  parameter int unsigned IDX_W      = $clog2(NUM_MOTORS)
);

  logic [NUM_MOTORS-1:0]                          enable_mask;
  logic                                           estop;
  logic                                           overrun_clear;
  logic signed [msj_pd_sched_pkg::PWM_W-1:0]      pwm_ref_in;
  logic [IDX_W-1:0]                               motor_sel;
  logic                                           ctrl_update;
  logic [NUM_MOTORS*msj_pd_sched_pkg::PWM_W-1:0]  pwm_out;
  logic [NUM_MOTORS-1:0]                          pwm_valid;
  logic                                           sweep_done;
  logic                                           busy;
  logic                                           overrun;

  // Scheduler side.
  modport master (
    input  enable_mask, estop, overrun_clear, pwm_ref_in,
    output motor_sel, ctrl_update, pwm_out, pwm_valid, sweep_done, busy, overrun
  );

  // Surrounding system side.
  modport slave (
    output enable_mask, estop, overrun_clear, pwm_ref_in,
    input  motor_sel, ctrl_update, pwm_out, pwm_valid, sweep_done, busy, overrun
  );

endinterface

// File: rtl/msj_tick_gen.sv
// Free-running sweep period counter; tick is high while the count sits at TICK_DIV-1.
module msj_tick_gen #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned        CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_PRE  = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] count;

  // Wrap the counter and register tick one cycle ahead so it aligns with CNT_LAST.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == CNT_LAST) ? '0 : CNT_W'(count + 1'b1);
      tick  <= (count == CNT_PRE);
    end
  end

endmodule

// File: rtl/msj_pd_scheduler.sv
// Sweeps one shared PD controller across all motors per tick and latches each PWM result.
module msj_pd_scheduler
  import msj_pd_sched_pkg::*;
#(
  parameter int unsigned NUM_MOTORS    = 8,
  parameter int unsigned TICK_DIV      = 500000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned IDX_W         = $clog2(NUM_MOTORS)
) (
  input  logic               clock,
  input  logic               reset,
  msj_pd_scheduler_if.master bus
);

  localparam int unsigned      WAIT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOTORS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(SETTLE_CYCLES - 1);

  sched_state_t          state, state_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [WAIT_W-1:0]     wait_cnt, wait_next;
  logic [NUM_MOTORS-1:0] mask, mask_next;
  logic                  tick;
  logic                  ovr_set_c;

  msj_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // A tick outside IDLE is dropped and flagged; estop suppresses the flag.
  assign ovr_set_c = tick && (state != IDLE) && !bus.estop;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      mask     <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      wait_cnt <= wait_next;
      mask     <= mask_next;
    end
  end

  // Next-state logic; estop parks the FSM in IDLE regardless of state.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    wait_next  = wait_cnt;
    mask_next  = mask;
    if (bus.estop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            mask_next  = bus.enable_mask;
            idx_next   = '0;
            state_next = SELECT;
          end
        end
        SELECT:  state_next = mask[idx] ? PULSE : NEXT;
        PULSE: begin
          wait_next  = '0;
          state_next = WAIT;
        end
        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state_next = CAPTURE;
          end else begin
            wait_next = WAIT_W'(wait_cnt + 1'b1);
          end
        end
        CAPTURE: state_next = NEXT;
        NEXT: begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = IDX_W'(idx + 1'b1);
            state_next = SELECT;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.motor_sel   <= '0;
      bus.ctrl_update <= 1'b0;
      bus.busy        <= 1'b0;
      bus.sweep_done  <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.pwm_valid   <= '0;
      bus.pwm_out     <= '0;
    end else begin
      bus.motor_sel   <= idx_next;
      bus.ctrl_update <= (state_next == PULSE);
      bus.busy        <= (state_next != IDLE);
      bus.sweep_done  <= (state_next == DONE);
      bus.overrun     <= ovr_set_c | (bus.overrun & ~bus.overrun_clear);
      bus.pwm_valid   <= '0;
      if (bus.estop) begin
        bus.pwm_out <= '0;
      end else if (state == CAPTURE) begin
        bus.pwm_out[PWM_W * 32'(idx) +: PWM_W] <= bus.pwm_ref_in;
        bus.pwm_valid[idx]                     <= 1'b1;
      end else if ((state == SELECT) && !mask[idx]) begin
        bus.pwm_out[PWM_W * 32'(idx) +: PWM_W] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_msj_pd_scheduler.sv
// Self-checking bench for msj_pd_scheduler with a scoreboard of expected PWM captures.
module tb_msj_pd_scheduler;

  localparam int unsigned NM     = 4;
  localparam int unsigned PW     = 32;
  localparam int          TDIV   = 64;
  localparam int          TDIV_O = 16;

  typedef struct {
    int idx;
    int val;
  } exp_t;

  logic clock    = 1'b0;
  logic rst_main = 1'b1;
  logic rst_ovr  = 1'b1;
  logic rst_any;
  logic mctrl_q, octrl_q;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  exp_t sb[$];
  int   ctrl_cyc[$];
  int   ctrl_sel[$];
  exp_t m_e;
  int   m_vi;

  msj_pd_scheduler_if #(.NUM_MOTORS(NM), .IDX_W(2)) mb ();
  msj_pd_scheduler_if #(.NUM_MOTORS(NM), .IDX_W(2)) ob ();

  msj_pd_scheduler #(
    .NUM_MOTORS(NM), .TICK_DIV(TDIV), .SETTLE_CYCLES(2), .IDX_W(2)
  ) u_dut (
    .clock (clock),
    .reset (rst_main),
    .bus   (mb)
  );

  msj_pd_scheduler #(
    .NUM_MOTORS(NM), .TICK_DIV(TDIV_O), .SETTLE_CYCLES(2), .IDX_W(2)
  ) u_dut_ovr (
    .clock (clock),
    .reset (rst_ovr),
    .bus   (ob)
  );

  always #5 clock = ~clock;

  assign rst_any = rst_main & rst_ovr;

  // Cycles since the most recent reset release.
  always @(posedge clock or posedge rst_any) begin
    if (rst_any) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Controller model for the main DUT: result appears one cycle after the update rising edge.
  always @(posedge clock) begin
    if (rst_main) begin
      mb.pwm_ref_in <= '0;
      mctrl_q       <= 1'b0;
    end else begin
      if (mb.ctrl_update && !mctrl_q) mb.pwm_ref_in <= 32'((int'(mb.motor_sel) + 1) * 100);
      mctrl_q <= mb.ctrl_update;
    end
  end

  // Controller model for the overrun DUT.
  always @(posedge clock) begin
    if (rst_ovr) begin
      ob.pwm_ref_in <= '0;
      octrl_q       <= 1'b0;
    end else begin
      if (ob.ctrl_update && !octrl_q) ob.pwm_ref_in <= 32'((int'(ob.motor_sel) + 1) * 100);
      octrl_q <= ob.ctrl_update;
    end
  end

  // Monitor: log update pulses and pop the scoreboard on every pwm_valid pulse.
  always @(negedge clock) begin
    if (!rst_main) begin
      if (mb.ctrl_update === 1'b1) begin
        ctrl_cyc.push_back(cyc);
        ctrl_sel.push_back(int'(mb.motor_sel));
      end
      if (mb.pwm_valid !== '0) begin
        n_checks++;
        if (!$onehot(mb.pwm_valid) || sb.size() == 0) begin
          n_fail++;
          $display("FAIL valid_unexpected: pwm_valid=%b pending=%0d at cyc %0d", mb.pwm_valid, sb.size(), cyc);
        end else begin
          m_e  = sb.pop_front();
          m_vi = -1;
          for (int i = 0; i < NM; i++) if (mb.pwm_valid[i]) m_vi = i;
          if (m_vi != m_e.idx || int'(slot(mb.pwm_out, m_vi)) != m_e.val) begin
            n_fail++;
            $display("FAIL capture: got motor %0d value %0d, expected motor %0d value %0d",
                     m_vi, int'(slot(mb.pwm_out, m_vi)), m_e.idx, m_e.val);
          end
        end
      end
    end
  end

  function automatic logic signed [31:0] slot(input logic [NM*PW-1:0] v, input int i);
    return v[i*PW +: PW];
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic reset_main(input logic [NM-1:0] m);
    rst_main = 1'b1;
    mb.estop = 1'b0;
    mb.overrun_clear = 1'b0;
    mb.enable_mask = m;
    sb.delete();
    ctrl_cyc.delete();
    ctrl_sel.delete();
    repeat (2) @(negedge clock);
    rst_main = 1'b0;
  endtask

  task automatic push_all();
    for (int i = 0; i < NM; i++) sb.push_back('{i, (i + 1) * 100});
  endtask

  // Wait for the next sweep to start and finish; bounded in both phases.
  task automatic run_sweep(output int t_start, output int t_done, output bit ok);
    int n;
    ok = 1'b0; t_start = -1; t_done = -1;
    n = 0;
    while (mb.busy === 1'b1 && n < 64) begin @(negedge clock); n++; end
    n = 0;
    while (mb.busy !== 1'b1 && n < 256) begin @(negedge clock); n++; end
    if (mb.busy === 1'b1) begin
      t_start = cyc;
      n = 0;
      while (mb.sweep_done !== 1'b1 && n < 128) begin @(negedge clock); n++; end
      if (mb.sweep_done === 1'b1) begin
        t_done = cyc;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    mb.enable_mask = 4'b0001; mb.estop = 1'b0; mb.overrun_clear = 1'b0;
    rst_main = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({mb.motor_sel, mb.ctrl_update, mb.busy, mb.sweep_done, mb.overrun, mb.pwm_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: sel=%0d upd=%b busy=%b done=%b ovr=%b valid=%b, expected all 0",
               mb.motor_sel, mb.ctrl_update, mb.busy, mb.sweep_done, mb.overrun, mb.pwm_valid);
    end
    n_checks++;
    if (mb.pwm_out !== '0) begin n_fail++; $display("FAIL reset_pwm: pwm_out=%h expected 0", mb.pwm_out); end
    rst_main = 1'b0;
    wait_cyc(TDIV - 1);
    n_checks++;
    if (mb.busy !== 1'b0) begin n_fail++; $display("FAIL early_start: busy=%b at cyc %0d expected 0", mb.busy, cyc); end
    wait_cyc(TDIV);
    n_checks++;
    if (mb.busy !== 1'b1) begin n_fail++; $display("FAIL first_tick: busy=%b at cyc %0d expected 1", mb.busy, cyc); end
    rst_main = 1'b1;
  endtask

  task automatic test_basic_sweep();
    int t0, t1; bit ok;
    reset_main(4'b1111);
    push_all();
    run_sweep(t0, t1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: start=%0d done=%0d", t0, t1); end
    n_checks++;
    if (t0 != TDIV) begin n_fail++; $display("FAIL basic_start: busy rose at %0d expected %0d", t0, TDIV); end
    n_checks++;
    if (t1 != TDIV - 1 + 25) begin n_fail++; $display("FAIL basic_done: sweep_done at %0d expected %0d", t1, TDIV + 24); end
    n_checks++;
    if (ctrl_cyc.size() != 4) begin
      n_fail++; $display("FAIL basic_pulses: %0d update pulses expected 4", ctrl_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ctrl_cyc[i] != TDIV + 1 + 6 * i || ctrl_sel[i] != i) begin
          n_fail++;
          $display("FAIL basic_pulse%0d: at %0d sel %0d expected at %0d sel %0d", i, ctrl_cyc[i], ctrl_sel[i], TDIV + 1 + 6 * i, i);
        end
      end
    end
    for (int i = 0; i < NM; i++) begin
      n_checks++;
      if (slot(mb.pwm_out, i) !== 32'((i + 1) * 100)) begin
        n_fail++; $display("FAIL basic_pwm%0d: got %0d expected %0d", i, slot(mb.pwm_out, i), (i + 1) * 100);
      end
    end
    n_checks++;
    if (mb.overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: overrun=%b expected 0", mb.overrun); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL basic_sb: %0d captures missing expected 0", sb.size()); end
    rst_main = 1'b1;
  endtask

  task automatic test_masked();
    int t0, t1; bit ok;
    int exp_v[4] = '{100, 0, 300, 0};
    reset_main(4'b1111);
    push_all();
    run_sweep(t0, t1, ok);
    mb.enable_mask = 4'b0101;
    ctrl_cyc.delete(); ctrl_sel.delete();
    sb.push_back('{0, 100});
    sb.push_back('{2, 300});
    run_sweep(t0, t1, ok);
    n_checks++;
    if (!ok || t0 != 2 * TDIV) begin n_fail++; $display("FAIL masked_start: busy rose at %0d expected %0d", t0, 2 * TDIV); end
    n_checks++;
    if (t1 - (t0 - 1) != 17) begin n_fail++; $display("FAIL masked_len: sweep length %0d expected 17", t1 - (t0 - 1)); end
    n_checks++;
    if (ctrl_sel.size() != 2) begin
      n_fail++; $display("FAIL masked_pulses: %0d update pulses expected 2", ctrl_sel.size());
    end else begin
      n_checks++;
      if (ctrl_sel[0] != 0 || ctrl_sel[1] != 2) begin
        n_fail++; $display("FAIL masked_sel: pulses for %0d,%0d expected 0,2", ctrl_sel[0], ctrl_sel[1]);
      end
    end
    for (int i = 0; i < NM; i++) begin
      n_checks++;
      if (int'(slot(mb.pwm_out, i)) != exp_v[i]) begin
        n_fail++; $display("FAIL masked_pwm%0d: got %0d expected %0d", i, slot(mb.pwm_out, i), exp_v[i]);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL masked_sb: %0d captures missing expected 0", sb.size()); end
    rst_main = 1'b1;
  endtask

  task automatic test_overrun();
    logic [NM*PW-1:0] exp_pwm;
    exp_pwm = {32'sd400, 32'sd300, 32'sd200, 32'sd100};
    rst_main = 1'b1; rst_ovr = 1'b1;
    ob.enable_mask = 4'b1111; ob.estop = 1'b0; ob.overrun_clear = 1'b0;
    repeat (2) @(negedge clock);
    rst_ovr = 1'b0;
    wait_cyc(31);
    n_checks++;
    if (ob.overrun !== 1'b0 || ob.busy !== 1'b1) begin n_fail++; $display("FAIL ovr_pre: overrun=%b busy=%b expected 0,1", ob.overrun, ob.busy); end
    wait_cyc(32);
    n_checks++;
    if (ob.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: overrun=%b at cyc 32 expected 1", ob.overrun); end
    wait_cyc(40);
    n_checks++;
    if (ob.sweep_done !== 1'b1) begin n_fail++; $display("FAIL ovr_done: sweep_done=%b at cyc 40 expected 1", ob.sweep_done); end
    wait_cyc(41);
    n_checks++;
    if (ob.pwm_out !== exp_pwm) begin n_fail++; $display("FAIL ovr_pwm: pwm_out=%h expected %h", ob.pwm_out, exp_pwm); end
    wait_cyc(47);
    n_checks++;
    if (ob.overrun !== 1'b1 || ob.busy !== 1'b0) begin n_fail++; $display("FAIL ovr_sticky: overrun=%b busy=%b expected 1,0", ob.overrun, ob.busy); end
    wait_cyc(48);
    n_checks++;
    if (ob.busy !== 1'b1) begin n_fail++; $display("FAIL ovr_restart: busy=%b at cyc 48 expected 1", ob.busy); end
    wait_cyc(49); ob.overrun_clear = 1'b1;
    wait_cyc(50); ob.overrun_clear = 1'b0;
    n_checks++;
    if (ob.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: overrun=%b expected 0", ob.overrun); end
    wait_cyc(64);
    n_checks++;
    if (ob.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_reset2: overrun=%b at cyc 64 expected 1", ob.overrun); end
    wait_cyc(69); ob.overrun_clear = 1'b1;
    wait_cyc(70); ob.overrun_clear = 1'b0;
    n_checks++;
    if (ob.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2: overrun=%b expected 0", ob.overrun); end
    wait_cyc(95); ob.overrun_clear = 1'b1;
    wait_cyc(96); ob.overrun_clear = 1'b0;
    n_checks++;
    if (ob.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: overrun=%b expected 1", ob.overrun); end
    wait_cyc(97);
    n_checks++;
    if (ob.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_hold: overrun=%b expected 1", ob.overrun); end
    rst_ovr = 1'b1;
  endtask

  task automatic test_estop();
    int t0, t1; bit ok; bit bad;
    reset_main(4'b1111);
    sb.push_back('{0, 100});
    sb.push_back('{1, 200});
    wait_cyc(78);
    n_checks++;
    if (slot(mb.pwm_out, 0) !== 32'sd100 || slot(mb.pwm_out, 1) !== 32'sd200 || mb.busy !== 1'b1) begin
      n_fail++; $display("FAIL estop_pre: pwm0=%0d pwm1=%0d busy=%b expected 100,200,1", slot(mb.pwm_out, 0), slot(mb.pwm_out, 1), mb.busy);
    end
    mb.estop = 1'b1;
    wait_cyc(79);
    n_checks++;
    if (mb.pwm_out !== '0 || mb.busy !== 1'b0 || mb.ctrl_update !== 1'b0 || mb.pwm_valid !== '0) begin
      n_fail++; $display("FAIL estop_apply: pwm_out=%h busy=%b upd=%b valid=%b expected all 0", mb.pwm_out, mb.busy, mb.ctrl_update, mb.pwm_valid);
    end
    bad = 1'b0;
    while (cyc < 90) begin
      @(negedge clock);
      if (mb.busy !== 1'b0 || mb.sweep_done !== 1'b0 || mb.ctrl_update !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL estop_hold: activity seen during estop, expected none"); end
    mb.estop = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL estop_sb: %0d captures missing expected 0", sb.size()); end
    ctrl_cyc.delete(); ctrl_sel.delete();
    push_all();
    run_sweep(t0, t1, ok);
    n_checks++;
    if (!ok || t0 != 2 * TDIV) begin n_fail++; $display("FAIL estop_restart: busy rose at %0d expected %0d", t0, 2 * TDIV); end
    n_checks++;
    if (ctrl_sel.size() == 0 || ctrl_sel[0] != 0) begin n_fail++; $display("FAIL estop_first_sel: first pulse not for motor 0 (%0d pulses)", ctrl_sel.size()); end
    n_checks++;
    if (slot(mb.pwm_out, 3) !== 32'sd400 || sb.size() != 0) begin
      n_fail++; $display("FAIL estop_resweep: pwm3=%0d pending=%0d expected 400,0", slot(mb.pwm_out, 3), sb.size());
    end
    rst_main = 1'b1;
  endtask

  task automatic test_async_reset();
    int t0, t1, n; bit ok;
    reset_main(4'b1111);
    push_all();
    run_sweep(t0, t1, ok);
    n = 0;
    while (mb.ctrl_update !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    n_checks++;
    if (mb.ctrl_update !== 1'b1) begin n_fail++; $display("FAIL areset_pulse: no update pulse within %0d cycles", n); end
    #2 rst_main = 1'b1;
    #1;
    n_checks++;
    if (mb.ctrl_update !== 1'b0 || mb.busy !== 1'b0 || mb.pwm_out !== '0) begin
      n_fail++; $display("FAIL areset_async: upd=%b busy=%b pwm_out=%h expected all 0", mb.ctrl_update, mb.busy, mb.pwm_out);
    end
    @(negedge clock);
    sb.delete(); ctrl_cyc.delete(); ctrl_sel.delete();
    rst_main = 1'b0;
    push_all();
    run_sweep(t0, t1, ok);
    n_checks++;
    if (!ok || t0 != TDIV) begin n_fail++; $display("FAIL areset_tick: busy rose at %0d expected %0d", t0, TDIV); end
    rst_main = 1'b1;
  endtask

  task automatic test_mask_change();
    int t0, t1; bit ok;
    reset_main(4'b1111);
    push_all();
    wait_cyc(71);
    n_checks++;
    if (mb.motor_sel !== 2'd1 || mb.busy !== 1'b1) begin n_fail++; $display("FAIL mchg_sel: motor_sel=%0d busy=%b expected 1,1", mb.motor_sel, mb.busy); end
    mb.enable_mask = 4'b0000;
    wait_cyc(TDIV + 24);
    n_checks++;
    if (mb.sweep_done !== 1'b1 || ctrl_cyc.size() != 4) begin
      n_fail++; $display("FAIL mchg_cur: sweep_done=%b pulses=%0d expected 1,4", mb.sweep_done, ctrl_cyc.size());
    end
    n_checks++;
    if (slot(mb.pwm_out, 2) !== 32'sd300 || slot(mb.pwm_out, 3) !== 32'sd400 || sb.size() != 0) begin
      n_fail++; $display("FAIL mchg_vals: pwm2=%0d pwm3=%0d pending=%0d expected 300,400,0", slot(mb.pwm_out, 2), slot(mb.pwm_out, 3), sb.size());
    end
    ctrl_cyc.delete(); ctrl_sel.delete();
    run_sweep(t0, t1, ok);
    n_checks++;
    if (!ok || t0 != 2 * TDIV || t1 != 2 * TDIV + 8) begin
      n_fail++; $display("FAIL mchg_next: start=%0d done=%0d expected %0d,%0d", t0, t1, 2 * TDIV, 2 * TDIV + 8);
    end
    n_checks++;
    if (ctrl_cyc.size() != 0 || mb.pwm_out !== '0) begin
      n_fail++; $display("FAIL mchg_zero: pulses=%0d pwm_out=%h expected 0,0", ctrl_cyc.size(), mb.pwm_out);
    end
    rst_main = 1'b1;
  endtask

  initial begin
    ob.enable_mask = '0; ob.estop = 1'b0; ob.overrun_clear = 1'b0;
    test_reset();
    test_basic_sweep();
    test_masked();
    test_overrun();
    test_estop();
    test_async_reset();
    test_mask_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
